shift_serializer: RTL and testbench

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

---
 rtl/shift_pkg.sv | 23 ++
 rtl/ser_bit_timer.sv | 33 +++
 rtl/shift_serializer.sv | 138 +++++++++++++
 tb/tb_shift_serializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift serializer slice.
// Build option: define SER_PARITY_EN to add an even-parity bit after the data bits.
package shift_pkg;

  // Level driven on ser_out whenever no frame bit is being sent
  localparam logic SER_IDLE = 1'b1;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } ser_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ser_state_t;
`endif

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period divider: counts 0..DIV-1 while running and pulses bit_tick on the last count.
// With DIV=1 the counter stays at 0 and bit_tick follows run every cycle.
module ser_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Advance the divider while a frame bit is on the line, wrapping at the end of each bit
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
    end else if (run) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign bit_tick = run && (div_cnt == DIV_LAST);

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial converter: loads a DATA_W-bit word and sends it LSB- or MSB-first,
// each bit held for DIV clock cycles, followed by a one-cycle done pulse.
// Build option: SER_PARITY_EN appends an even-parity bit (held DIV cycles) before done.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              dir,
  output logic              ser_out,
  output logic              ser_en,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  ser_state_t        state;
  ser_state_t        state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              dir_q;
  logic              accept;
  logic              timer_run;
  logic              bit_tick;
`ifdef SER_PARITY_EN
  logic              parity_q;
`endif

  assign accept = s_valid && s_ready;

`ifdef SER_PARITY_EN
  assign timer_run = (state == ST_SHIFT) || (state == ST_PARITY);
`else
  assign timer_run = (state == ST_SHIFT);
`endif

  ser_bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .run      (timer_run),
    .bit_tick (bit_tick)
  );

  // State register; reset wins over any accept in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Word register, latched bit order and bit counter; shifts once per completed bit
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      dir_q     <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (accept) begin
      shift_reg <= s_data;
      bit_cnt   <= '0;
      dir_q     <= dir;
`ifdef SER_PARITY_EN
      parity_q  <= ^s_data;
`endif
    end else if ((state == ST_SHIFT) && bit_tick) begin
      if (dir_q) begin
        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
      end else begin
        shift_reg <= {1'b0, shift_reg[DATA_W-1:1]};
      end
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Next-state and output decode, driven only by state and internal registers (s_ready aside)
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    ser_en     = 1'b0;
    ser_out    = SER_IDLE;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy    = 1'b1;
        ser_en  = 1'b1;
        ser_out = dir_q ? shift_reg[DATA_W-1] : shift_reg[0];
        if (bit_tick && (bit_cnt == BIT_LAST)) begin
`ifdef SER_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_DONE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        busy    = 1'b1;
        ser_en  = 1'b1;
        ser_out = parity_q;
        if (bit_tick) begin
          state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: two instances (DIV=4 and DIV=1) share data/dir/reset and
// are checked cycle by cycle against an expected bit list built from the input word.
module tb_shift_serializer;

  localparam int DATA_W = 8;
  localparam int DIV_A  = 4;
  localparam int DIV_B  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] s_data;
  logic              dir;
  logic [1:0]        valid;
  logic [1:0]        ready;
  logic [1:0]        ser;
  logic [1:0]        en;
  logic [1:0]        busy;
  logic [1:0]        done;

  int tests_run    = 0;
  int tests_failed = 0;

  bit exp_bits[$];

  shift_serializer #(.DATA_W(DATA_W), .DIV(DIV_A)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (valid[0]),
    .s_ready (ready[0]),
    .dir     (dir),
    .ser_out (ser[0]),
    .ser_en  (en[0]),
    .busy    (busy[0]),
    .done    (done[0])
  );

  shift_serializer #(.DATA_W(DATA_W), .DIV(DIV_B)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (valid[1]),
    .s_ready (ready[1]),
    .dir     (dir),
    .ser_out (ser[1]),
    .ser_en  (en[1]),
    .busy    (busy[1]),
    .done    (done[1])
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input int idx, input string tag);
    checkOutput({tag, "_ready"}, 32'(ready[idx]), 32'd1);
    checkOutput({tag, "_busy"},  32'(busy[idx]),  32'd0);
    checkOutput({tag, "_en"},    32'(en[idx]),    32'd0);
    checkOutput({tag, "_ser"},   32'(ser[idx]),   32'd1);
    checkOutput({tag, "_done"},  32'(done[idx]),  32'd0);
  endtask

  // Sends one word on instance idx and checks every cycle of the frame. Called and
  // returning at a falling edge; on return the instance is idle in cycle T0+span+2.
  // With hold=1 s_valid stays high carrying next_data/next_dir for a back-to-back accept.
  task automatic applyStimulus(input int idx, input logic [DATA_W-1:0] data, input logic d,
                               input bit hold, input logic [DATA_W-1:0] next_data,
                               input logic next_d, input string tag);
    int div;
    int span;
    int waited;
    div = (idx == 0) ? DIV_A : DIV_B;
    exp_bits.delete();
    for (int k = 0; k < DATA_W; k++) begin
      exp_bits.push_back(d ? data[DATA_W-1-k] : data[k]);
    end
`ifdef SER_PARITY_EN
    exp_bits.push_back(^data);
`endif
    span = exp_bits.size() * div;

    waited = 0;
    while (ready[idx] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_accept_ready"}, 32'(ready[idx]), 32'd1);

    s_data     = data;
    dir        = d;
    valid[idx] = 1'b1;
    @(negedge clk);

    for (int c = 1; c <= span; c++) begin
      checkOutput({tag, "_ser"},   32'(ser[idx]),   32'(exp_bits[(c - 1) / div]));
      checkOutput({tag, "_en"},    32'(en[idx]),    32'd1);
      checkOutput({tag, "_busy"},  32'(busy[idx]),  32'd1);
      checkOutput({tag, "_ready"}, 32'(ready[idx]), 32'd0);
      checkOutput({tag, "_done"},  32'(done[idx]),  32'd0);
      if (hold) begin
        s_data = next_data;
        dir    = next_d;
      end else begin
        valid[idx] = 1'b0;
        s_data     = DATA_W'($urandom);
        dir        = 1'($urandom);
      end
      @(negedge clk);
    end

    checkOutput({tag, "_done_pulse"}, 32'(done[idx]),  32'd1);
    checkOutput({tag, "_done_en"},    32'(en[idx]),    32'd0);
    checkOutput({tag, "_done_ser"},   32'(ser[idx]),   32'd1);
    checkOutput({tag, "_done_busy"},  32'(busy[idx]),  32'd1);
    checkOutput({tag, "_done_ready"}, 32'(ready[idx]), 32'd0);
    @(negedge clk);
    checkIdle(idx, {tag, "_after"});
  endtask

  initial begin
    int done_seen;
    rst    = 1'b1;
    valid  = 2'b00;
    s_data = '0;
    dir    = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle(0, "reset_a");
    checkIdle(1, "reset_b");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, "a5_lsb_div4");
    applyStimulus(1, 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, "81_msb_div1");
    applyStimulus(1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, "07_lsb_div1");

    applyStimulus(0, 8'h3C, 1'b0, 1'b1, 8'hC3, 1'b1, "b2b_first");
    applyStimulus(0, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0, "b2b_second");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(i % 2, DATA_W'($urandom), 1'($urandom), 1'b0, 8'h00, 1'b0, "random");
    end

    s_data   = 8'hFF;
    dir      = 1'b0;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("midrst_busy_before", 32'(busy[0]), 32'd1);
    rst      = 1'b1;
    valid[1] = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    valid[1] = 1'b0;
    checkIdle(0, "midrst_a");
    checkIdle(1, "rst_accept_b");
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || busy[0] !== 1'b0 || busy[1] !== 1'b0) done_seen++;
    end
    checkOutput("midrst_no_activity", 32'(done_seen), 32'd0);

    applyStimulus(0, DATA_W'($urandom), 1'($urandom), 1'b0, 8'h00, 1'b0, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
